// File: rtl/fp_positn_mul_serial.sv
// Bit-serial posit(PN,ES) x FP16 multiplier. The weight is consumed MSB-first,
// one bit per cycle, and the result is an unnormalised sign/exponent/mantissa.
module fp_positn_mul_serial #(
  parameter int ACT_EXP   = 5,
  parameter int ACT_MAN   = 10,
  parameter int PN        = 8,
  parameter int ES        = 1,
  parameter int EXP_OUT_W = 8,
  localparam int FW       = PN - 3,
  localparam int MW       = ACT_MAN + 2 + FW,
  localparam int PW       = $clog2(PN + 1),
  localparam int AW       = 1 + ACT_EXP + ACT_MAN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        act,
  input  logic [PN-1:0]        w,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 set,
  input  logic [PW-1:0]        precision,
  output logic                 sign_out,
  output logic [EXP_OUT_W-1:0] exp_out,
  output logic [MW-1:0]        mant_out,
  output logic                 zero_out,
  output logic                 NaR_out,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SIGN   = 3'd1,
    REGIME = 3'd2,
    EXP    = 3'd3,
    FRAC   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0]  prec_q, prec_d;
  logic [AW-1:0]  act_q, act_d;
  logic [PN-1:0]  w_q, w_d;
  logic [PW-1:0]  left_q, left_d;
  logic           sgn_q, sgn_d;
  logic           reg_bit_q, reg_bit_d;
  logic [PW-1:0]  run_q, run_d;
  logic [2:0]     e_q, e_d;
  logic [1:0]     ecnt_q, ecnt_d;
  logic [MW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  fsh_q, fsh_d;
  logic           zero_q, zero_d;
  logic           nar_q, nar_d;

  logic                 cur_bit;
  logic                 last_bit;
  logic                 regime_end;
  logic                 exp_end;
  logic [PW-1:0]        n_sel;
  logic [PW-1:0]        align_sh;
  logic [PN-1:0]        w_aligned;
  logic [ACT_EXP-1:0]   act_exp_in;
  logic [MW-1:0]        mant_full;
  logic [2:0]           e_fin;
  logic [EXP_OUT_W-1:0] k_val;
  logic [EXP_OUT_W-1:0] exp_full;
  logic                 special;

  function automatic logic [PW-1:0] clamp_prec(input logic [PW-1:0] p);
    return (p < PW'(2) || p > PW'(PN)) ? PW'(PN) : p;
  endfunction

  // The weight is left-aligned at accept so the current bit is always the MSB.
  always_comb begin
    cur_bit    = w_q[PN-1];
    last_bit   = (left_q == PW'(1));
    regime_end = last_bit || ((run_q != '0) && (cur_bit != reg_bit_q));
    exp_end    = last_bit || ((ecnt_q + 2'd1) == 2'(ES));
    n_sel      = (set) ? clamp_prec(precision) : prec_q;
    align_sh   = PW'(PN) - n_sel;
    w_aligned  = w << align_sh;
    act_exp_in = act[AW-2:ACT_MAN];
    mant_full  = MW'({1'b1, act_q[ACT_MAN-1:0]});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SIGN;
      SIGN:    state_d = REGIME;
      REGIME:  if (regime_end) begin
                 if (last_bit)     state_d = DONE;
                 else if (ES > 0)  state_d = EXP;
                 else              state_d = FRAC;
               end
      EXP:     if (exp_end) state_d = last_bit ? DONE : FRAC;
      FRAC:    if (last_bit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    prec_d    = prec_q;
    act_d     = act_q;
    w_d       = w_q;
    left_d    = left_q;
    sgn_d     = sgn_q;
    reg_bit_d = reg_bit_q;
    run_d     = run_q;
    e_d       = e_q;
    ecnt_d    = ecnt_q;
    acc_d     = acc_q;
    fsh_d     = fsh_q;
    zero_d    = zero_q;
    nar_d     = nar_q;
    case (state_q)
      IDLE: begin
        if (set) prec_d = clamp_prec(precision);
        if (in_valid) begin
          act_d  = act;
          w_d    = w_aligned;
          left_d = n_sel;
          run_d  = '0;
          e_d    = '0;
          ecnt_d = '0;
          // Seeding the accumulator here is equivalent to seeding on FRAC entry.
          acc_d  = MW'({1'b1, act[ACT_MAN-1:0]}) << FW;
          fsh_d  = PW'(FW - 1);
          nar_d  = (w_aligned == {1'b1, {(PN-1){1'b0}}}) || (&act_exp_in);
          zero_d = (w_aligned == '0) || (act_exp_in == '0);
        end
      end
      SIGN: begin
        sgn_d  = cur_bit;
        w_d    = w_q << 1;
        left_d = left_q - PW'(1);
      end
      REGIME: begin
        w_d    = w_q << 1;
        left_d = left_q - PW'(1);
        if (run_q == '0) begin
          reg_bit_d = cur_bit;
          run_d     = PW'(1);
        end else if (cur_bit == reg_bit_q) begin
          run_d = run_q + PW'(1);
        end
      end
      EXP: begin
        w_d    = w_q << 1;
        left_d = left_q - PW'(1);
        e_d    = {e_q[1:0], cur_bit};
        ecnt_d = ecnt_q + 2'd1;
      end
      FRAC: begin
        w_d    = w_q << 1;
        left_d = left_q - PW'(1);
        fsh_d  = fsh_q - PW'(1);
        if (cur_bit) acc_d = acc_q + (mant_full << fsh_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prec_q    <= PW'(PN);
      act_q     <= '0;
      w_q       <= '0;
      left_q    <= '0;
      sgn_q     <= 1'b0;
      reg_bit_q <= 1'b0;
      run_q     <= '0;
      e_q       <= '0;
      ecnt_q    <= '0;
      acc_q     <= '0;
      fsh_q     <= '0;
      zero_q    <= 1'b0;
      nar_q     <= 1'b0;
    end else begin
      prec_q    <= prec_d;
      act_q     <= act_d;
      w_q       <= w_d;
      left_q    <= left_d;
      sgn_q     <= sgn_d;
      reg_bit_q <= reg_bit_d;
      run_q     <= run_d;
      e_q       <= e_d;
      ecnt_q    <= ecnt_d;
      acc_q     <= acc_d;
      fsh_q     <= fsh_d;
      zero_q    <= zero_d;
      nar_q     <= nar_d;
    end
  end

  // Exponent bits truncated by the end of the word count as trailing zeros.
  always_comb begin
    e_fin    = e_q << (2'(ES) - ecnt_q);
    k_val    = reg_bit_q ? (EXP_OUT_W'(run_q) - EXP_OUT_W'(1))
                         : (EXP_OUT_W'(0) - EXP_OUT_W'(run_q));
    exp_full = EXP_OUT_W'(act_q[AW-2:ACT_MAN]) + (k_val << ES) + EXP_OUT_W'(e_fin);
  end

  always_comb begin
    out_valid = (state_q == DONE);
    in_ready  = (state_q == IDLE);
    special   = zero_q | nar_q;
    NaR_out   = out_valid & nar_q;
    zero_out  = out_valid & zero_q & ~nar_q;
    sign_out  = out_valid & ~special & (act_q[AW-1] ^ sgn_q);
    exp_out   = (out_valid && !special) ? exp_full : '0;
    mant_out  = (out_valid && !special) ? acc_q : '0;
  end

endmodule
